// File: rtl/clock_divider_pkg.sv
// Shared constants for the multi-channel clock divider: output modes and
// the default counter width / reset divisor (1 Hz from a 100 MHz source).
package clock_divider_pkg;
  localparam logic        MODE_TOGGLE = 1'b0;
  localparam logic        MODE_PULSE  = 1'b1;
  localparam int          DEF_CNT_W   = 27;
  localparam int unsigned DEF_DIV     = 50_000_000;
endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: wrap counter, active/pending divisor+mode, and the
// registered clk/tick outputs. Pending config is applied only at a period boundary.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int unsigned RST_DIV = DEF_DIV
)(
  input  logic             clk_in,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_mode,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend_vld
);
  logic [CNT_W-1:0] r_cnt, r_act_div, r_pend_div;
  logic             r_act_mode, r_pend_mode, r_pend_vld, r_clk, r_tick;
  logic             w_wrap, w_apply, w_mode_chg;

  assign w_wrap     = i_enable && (r_cnt == r_act_div - 1'b1);
  // A disabled channel has no boundary to wait for, so it takes pending config at once.
  assign w_apply    = r_pend_vld && (i_sync || !i_enable || w_wrap);
  assign w_mode_chg = w_apply && (r_pend_mode != r_act_mode);

  // Loads only arrive while nothing is pending, so apply and load never collide.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_act_div   <= CNT_W'(RST_DIV);
      r_act_mode  <= MODE_TOGGLE;
      r_pend_div  <= '0;
      r_pend_mode <= MODE_TOGGLE;
      r_pend_vld  <= 1'b0;
    end else if (w_apply) begin
      r_act_div   <= r_pend_div;
      r_act_mode  <= r_pend_mode;
      r_pend_vld  <= 1'b0;
    end else if (i_load) begin
      r_pend_div  <= i_div;
      r_pend_mode <= i_mode;
      r_pend_vld  <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_sync) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (!i_enable) begin
      r_tick <= 1'b0;
      if (r_pend_vld) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
      end
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
      if (w_mode_chg)                r_clk <= 1'b0;
      else if (r_act_mode == MODE_PULSE) r_clk <= 1'b1;
      else                           r_clk <= ~r_clk;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
      if (r_act_mode == MODE_PULSE) r_clk <= 1'b0;
    end
  end

  assign o_clk      = r_clk;
  assign o_tick     = r_tick;
  assign o_pend_vld = r_pend_vld;
endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider / tick generator: config decode,
// per-channel ready mux and a registered reject flag around NUM_CH channels.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter  int          NUM_CH      = 4,
  parameter  int          CNT_W       = DEF_CNT_W,
  parameter  int unsigned DEFAULT_DIV = DEF_DIV,
  // One spare code point so an out-of-range channel is always expressible.
  localparam int          CH_W        = $clog2(NUM_CH + 1)
)(
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync_all,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  localparam logic [CH_W-1:0] CH_LIM = CH_W'(NUM_CH);

  logic [NUM_CH-1:0] w_pend_vld, w_load;
  logic              w_ch_ok, w_div_ok, w_accept, r_err;

  assign w_ch_ok  = cfg_ch < CH_LIM;
  assign w_div_ok = |cfg_div;
  assign w_accept = cfg_valid & cfg_ready;

  // Out-of-range channels stay ready so the bad request is taken and flagged.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_W'(i)) cfg_ready = ~w_pend_vld[i];
  end

  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_load[i] = w_accept & w_div_ok & (cfg_ch == CH_W'(i));
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_accept & ~(w_ch_ok & w_div_ok);
  end

  assign cfg_err = r_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_divider_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .reset      (reset),
      .i_enable   (enable[g]),
      .i_sync     (sync_all),
      .i_load     (w_load[g]),
      .i_div      (cfg_div),
      .i_mode     (cfg_mode),
      .o_clk      (clk_out[g]),
      .o_tick     (tick[g]),
      .o_pend_vld (w_pend_vld[g])
    );
  end
endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench: the driver steps a period-countdown reference model and
// queues expected outputs; a monitor pops and compares them every cycle.
module tb_clock_divider_multi;
  localparam int NUM_CH = 4;

  logic       clk_in = 1'b0;
  logic       reset, sync_all, cfg_valid, cfg_ready, cfg_mode, cfg_err;
  logic [3:0] enable, clk_out, tick;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_div;

  clock_divider_multi #(.NUM_CH(NUM_CH), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .sync_all(sync_all),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_err = 0;
  logic       q_rdy[$];
  logic [8:0] q_out[$];

  // Reference model: cycles left in the current period, plus output bits.
  int         m_rem[4], m_div[4], m_pdiv[4];
  logic [3:0] m_mode, m_pmode, m_pend, m_clk, m_tick;
  logic       m_err;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_rem[c] = 4; m_div[c] = 4; m_pdiv[c] = 0;
    end
    m_mode = '0; m_pmode = '0; m_pend = '0; m_clk = '0; m_tick = '0; m_err = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] en, input bit sync, input bit acc,
                                     input int ch, input int dv, input bit md);
    m_err = acc && (dv == 0 || ch >= NUM_CH);
    for (int c = 0; c < 4; c++) begin
      bit ends = en[c] && (m_rem[c] == 1);
      bit app  = m_pend[c] && (sync || !en[c] || ends);
      bit nmd  = app ? m_pmode[c] : m_mode[c];
      int ndv  = app ? m_pdiv[c] : m_div[c];
      if (sync) begin
        m_tick[c] = 0; m_clk[c] = 0; m_rem[c] = ndv;
      end else if (!en[c]) begin
        m_tick[c] = 0;
        if (app) begin m_clk[c] = 0; m_rem[c] = ndv; end
      end else if (ends) begin
        m_tick[c] = 1; m_rem[c] = ndv;
        if (nmd != m_mode[c]) m_clk[c] = 0;
        else if (nmd)         m_clk[c] = 1;
        else                  m_clk[c] = ~m_clk[c];
      end else begin
        m_rem[c]--; m_tick[c] = 0;
        if (m_mode[c]) m_clk[c] = 0;
      end
      if (app) begin
        m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c]; m_pend[c] = 0;
      end else if (acc && ch == c && dv != 0) begin
        m_pdiv[c] = dv; m_pmode[c] = md; m_pend[c] = 1;
      end
    end
  endfunction

  task automatic step(input bit rst, input logic [3:0] en, input bit sync, input bit v,
                      input int ch, input int dv, input bit md, output bit acc);
    bit rdy, prev_rst;
    @(negedge clk_in);
    prev_rst = reset;
    reset = rst; enable = en; sync_all = sync; cfg_valid = v;
    cfg_ch = 3'(ch); cfg_div = 8'(dv); cfg_mode = md;
    rdy = (ch < NUM_CH) ? !m_pend[ch] : 1'b1;
    acc = v && rdy && !rst;
    if (rst) begin model_reset(); rdy = 1'b1; end
    else model_step(en, sync, acc, ch, dv, md);
    q_rdy.push_back(rdy);
    q_out.push_back({m_clk, m_tick, m_err});
    if (rst && !prev_rst) begin
      #1;
      chk("async_reset_out", {clk_out, tick}, 8'h00);
    end
  endtask

  task automatic idle(input int n, input logic [3:0] en);
    bit a;
    repeat (n) step(0, en, 0, 0, 0, 1, 0, a);
  endtask

  task automatic wr(input int ch, input int dv, input bit md, input logic [3:0] en);
    bit a = 0;
    for (int i = 0; i < 64 && !a; i++) step(0, en, 0, 1, ch, dv, md, a);
    if (!a) chk("cfg_accept_timeout", 8'h00, 8'h01);
  endtask

  initial begin
    logic r;
    logic [8:0] e;
    forever begin
      @(negedge clk_in); #1;
      if (q_rdy.size() > 0) begin
        r = q_rdy.pop_front();
        chk("cfg_ready", {7'b0, cfg_ready}, {7'b0, r});
      end
      @(posedge clk_in); #1;
      if (q_out.size() > 0) begin
        e = q_out.pop_front();
        chk("clk_out", {4'b0, clk_out}, {4'b0, e[8:5]});
        chk("tick",    {4'b0, tick},    {4'b0, e[4:1]});
        chk("cfg_err", {7'b0, cfg_err}, {7'b0, e[0]});
      end
    end
  end

  initial begin
    bit a;
    logic [3:0] en;
    reset = 1'b1; enable = '0; sync_all = 0; cfg_valid = 0;
    cfg_ch = '0; cfg_div = 8'd1; cfg_mode = 0;
    model_reset();
    repeat (3) step(1, 4'h0, 0, 0, 0, 1, 0, a);
    idle(20, 4'hF);                                   // default divisor 4 on all channels
    wr(1, 3, 1, 4'hF); idle(20, 4'hF);                // ch1 -> pulse, div 3
    wr(2, 5, 0, 4'hF); wr(2, 2, 1, 4'hF); idle(20, 4'hF); // back-to-back on ch2
    wr(0, 0, 0, 4'hF); wr(5, 3, 1, 4'hF); wr(7, 9, 0, 4'hF); idle(12, 4'hF);
    idle(2, 4'hF); idle(10, 4'hE); idle(12, 4'hF);    // freeze ch0 mid-count
    wr(0, 3, 1, 4'hF); wr(1, 5, 0, 4'hF); wr(2, 7, 1, 4'hF); wr(3, 2, 0, 4'hF);
    idle(20, 4'hF);
    step(0, 4'hF, 1, 0, 0, 1, 0, a); idle(10, 4'hF);
    step(1, 4'hF, 0, 0, 0, 1, 0, a); step(1, 4'hF, 0, 0, 0, 1, 0, a);
    idle(12, 4'hF);
    en = 4'hF;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) en = 4'($urandom);
      step($urandom_range(0, 399) == 0, en, $urandom_range(0, 49) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 5), $urandom_range(0, 9),
           1'($urandom), a);
    end
    idle(5, 4'hF);
    @(posedge clk_in); #3;
    chk("scoreboard_drained", 8'(q_out.size() + q_rdy.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
